// File: rtl/mul_rr_arbiter.sv
// Round-robin front end that shares one WIDTHxWIDTH unsigned multiplier among NREQ
// requesters, with valid/ready handshakes on both the request and response side.
module mul_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  busy,
    output logic [CNTW-1:0]       op_count
);

    localparam int IDXW = $clog2(NREQ);
    localparam int EXTW = IDXW + 1;
    localparam logic [EXTW-1:0] NREQ_EXT = EXTW'(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  grant_idx;
    logic [IDXW-1:0]  pick;
    logic [IDXW-1:0]  ptr_after;
    logic             found;
    logic             req_hs;
    logic             rsp_hs;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : arbitration
        logic [EXTW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + EXTW'(k);
            if (cand >= NREQ_EXT) begin
                cand = cand - NREQ_EXT;
            end
            if (!found && req_valid[cand[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        req_hs    = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[pick] = 1'b1;
                    req_hs          = 1'b1;
                    state_nxt       = CALC;
                end
            end
            CALC: state_nxt = RESP;
            RESP: begin
                rsp_valid[grant_idx] = 1'b1;
                if (rsp_ready[grant_idx]) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign ptr_after = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            if (req_hs) begin
                grant_idx <= pick;
                a_lat     <= req_a[int'(pick)*WIDTH +: WIDTH];
                b_lat     <= req_b[int'(pick)*WIDTH +: WIDTH];
            end
            if (state == CALC) begin
                rsp_data <= mul_full(a_lat, b_lat);
            end
            // The pointer only moves on completion, so the finisher drops to lowest priority.
            if (rsp_hs) begin
                op_count <= op_count + CNTW'(1);
                rr_ptr   <= ptr_after;
            end
        end
    end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Randomized self-checking bench for mul_rr_arbiter against a behavioural
// round-robin / product model.
module tb_mul_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '0;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  busy;
    logic [CNTW-1:0]       op_count;

    mul_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    int               m_ptr = 0;
    logic [CNTW-1:0]  m_count = '0;

    function automatic int model_grant(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_arr[i];
            req_b[i*WIDTH +: WIDTH] = b_arr[i];
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = $urandom;
            b_arr[i] = $urandom;
        end
        pack();
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        m_ptr = 0;
        m_count = '0;
        cycle();
    endtask

    // One full transaction: accept, CALC, RESP held for 'hold' cycles, then handshake.
    task automatic do_op(input logic [NREQ-1:0] mask, input bit keep_valid, input int hold,
                         output int g, output logic [2*WIDTH-1:0] got);
        logic [NREQ-1:0]    oh;
        logic [2*WIDTH-1:0] exp_p;
        pack();
        req_valid = mask;
        rsp_ready = '0;
        #1;
        g = model_grant(mask, m_ptr);
        oh = '0;
        oh[g] = 1'b1;
        exp_p = {{WIDTH{1'b0}}, a_arr[g]} * {{WIDTH{1'b0}}, b_arr[g]};
        n_checks++;
        if (req_ready !== oh) begin
            n_fail++;
            $display("FAIL grant: req_ready=%b expected %b (mask %b)", req_ready, oh, mask);
        end
        cycle();
        if (!keep_valid) req_valid = '0;
        scramble();
        #1;
        n_checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL calc_cycle: req_ready=%b rsp_valid=%b busy=%b expected 0000 0000 1",
                     req_ready, rsp_valid, busy);
        end
        cycle();
        got = rsp_data;
        n_checks++;
        if (rsp_valid !== oh || rsp_data !== exp_p) begin
            n_fail++;
            $display("FAIL response: rsp_valid=%b data=%h expected %b %h", rsp_valid, rsp_data, oh, exp_p);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = NREQ'($urandom) & ~oh;
            scramble();
            cycle();
            n_checks++;
            if (rsp_valid !== oh || rsp_data !== exp_p || req_ready !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold: rsp_valid=%b data=%h req_ready=%b expected %b %h 0000",
                         rsp_valid, rsp_data, req_ready, oh, exp_p);
            end
        end
        rsp_ready = keep_valid ? '1 : oh;
        cycle();
        m_count = m_count + 1'b1;
        m_ptr = (g + 1) % NREQ;
        n_checks++;
        if (op_count !== m_count || rsp_valid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL complete: op_count=%h rsp_valid=%b busy=%b expected %h 0000 0",
                     op_count, rsp_valid, busy, m_count);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || op_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req_ready=%b rsp_valid=%b data=%h busy=%b op_count=%h expected all zero",
                     req_ready, rsp_valid, rsp_data, busy, op_count);
        end
    endtask

    task automatic test_basic();
        int g;
        logic [2*WIDTH-1:0] got;
        scramble();
        a_arr[0] = 32'd3;
        b_arr[0] = 32'd5;
        do_op(4'b0001, 1'b0, 0, g, got);
        n_checks++;
        if (got !== 64'd15 || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_3x5: data=%0d op_count=%0d expected 15 1", got, op_count);
        end
    endtask

    task automatic test_idle_withdraw();
        req_valid = '0;
        rsp_ready = '0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_checks++;
            if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL idle: req_ready=%b busy=%b rsp_valid=%b expected 0000 0 0000", req_ready, busy, rsp_valid);
            end
        end
        req_valid = 4'b0100;
        #1;
        req_valid = '0;
        cycle();
        n_checks++;
        if (busy !== 1'b0 || op_count !== m_count) begin
            n_fail++;
            $display("FAIL withdraw: busy=%b op_count=%h expected 0 %h", busy, op_count, m_count);
        end
    endtask

    task automatic test_edges();
        int g;
        logic [2*WIDTH-1:0] got;
        a_arr[2] = 32'hFFFF_FFFF;
        b_arr[2] = 32'hFFFF_FFFF;
        do_op(4'b0100, 1'b0, 1, g, got);
        n_checks++;
        if (g != 2 || got !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL max_square: grant=%0d data=%h expected 2 fffffffe00000001", g, got);
        end
        a_arr[0] = 32'h0;
        b_arr[0] = 32'hDEAD_BEEF;
        do_op(4'b0001, 1'b0, 0, g, got);
        n_checks++;
        if (got !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_operand: data=%h expected 0", got);
        end
    endtask

    task automatic test_round_robin();
        int g;
        logic [2*WIDTH-1:0] got;
        apply_reset();
        scramble();
        for (int n = 0; n < 5; n++) begin
            do_op(4'b1111, 1'b1, 0, g, got);
            n_checks++;
            if (g != n % NREQ) begin
                n_fail++;
                $display("FAIL rr_order: op %0d granted %0d expected %0d", n, g, n % NREQ);
            end
        end
        n_checks++;
        if (op_count !== 16'd5) begin
            n_fail++;
            $display("FAIL rr_count: op_count=%0d expected 5", op_count);
        end
    endtask

    task automatic test_hold();
        int g;
        logic [2*WIDTH-1:0] got;
        do_op(4'b1010, 1'b1, 10, g, got);
        n_checks++;
        if (g != 1) begin
            n_fail++;
            $display("FAIL hold_grant: granted %0d expected 1", g);
        end
        do_op(4'b1000, 1'b0, 0, g, got);
        n_checks++;
        if (g != 3) begin
            n_fail++;
            $display("FAIL after_hold: granted %0d expected 3", g);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        logic [2*WIDTH-1:0] got;
        req_valid = 4'b0001;
        #1;
        cycle();
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || op_count !== '0 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_calc: rsp_valid=%b busy=%b op_count=%h data=%h expected zeros",
                     rsp_valid, busy, op_count, rsp_data);
        end
        cycle();
        rst_n = 1'b1;
        req_valid = 4'b0100;
        #1;
        cycle();
        req_valid = '0;
        cycle();
        n_checks++;
        if (rsp_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL pre_reset_resp: rsp_valid=%b expected 0100", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || op_count !== '0 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: rsp_valid=%b busy=%b op_count=%h data=%h expected zeros",
                     rsp_valid, busy, op_count, rsp_data);
        end
        cycle();
        rst_n = 1'b1;
        m_ptr = 0;
        m_count = '0;
        cycle();
        n_checks++;
        if (rsp_valid !== '0 || op_count !== '0) begin
            n_fail++;
            $display("FAIL post_reset: rsp_valid=%b op_count=%h expected 0000 0", rsp_valid, op_count);
        end
        do_op(4'b1111, 1'b0, 0, g, got);
        n_checks++;
        if (g != 0) begin
            n_fail++;
            $display("FAIL post_reset_grant: granted %0d expected 0", g);
        end
    endtask

    task automatic test_random();
        int g;
        logic [2*WIDTH-1:0] got;
        logic [NREQ-1:0] mask;
        for (int n = 0; n < 40; n++) begin
            scramble();
            if ($urandom_range(0, 7) == 0) a_arr[$urandom_range(0, NREQ-1)] = '0;
            if ($urandom_range(0, 7) == 0) b_arr[$urandom_range(0, NREQ-1)] = '1;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            do_op(mask, 1'($urandom_range(0, 1)), $urandom_range(0, 3), g, got);
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        int g;
        logic [2*WIDTH-1:0] got;
        req_valid = '0;
        rsp_ready = '0;
        force dut.op_count = 16'hFFFF;
        cycle();
        release dut.op_count;
        #1;
        m_count = 16'hFFFF;
        n_checks++;
        if (op_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL preload: op_count=%h expected ffff", op_count);
        end
        scramble();
        do_op(4'b0001, 1'b0, 0, g, got);
        n_checks++;
        if (op_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: op_count=%h expected 0000", op_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_idle_withdraw();
        test_edges();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_rr_arbiter.md
Name: mul_rr_arbiter

Overview:
- Shares one 32x32 unsigned multiplier (64-bit product) among NREQ requesters.
- Uses round-robin arbitration with per-requester valid/ready request and response handshakes.
- Latches operands, registers the product, and holds the response until the granted requester accepts it.
- Sits between ALU32 issue ports and the single multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand width; product is 2*WIDTH
CNTW, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester request accept, at most one bit set
req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B, same packing as req_a
rsp_valid  output  NREQ  per-requester result valid, at most one bit set
rsp_ready  input  NREQ  per-requester result accept
rsp_data  output  2*WIDTH  registered product, shared by all requesters
busy  output  1  high whenever state is not IDLE
op_count  output  CNTW  completed operations, wraps modulo 2^CNTW

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; rr_ptr 0; req_ready 0; rsp_valid 0; rsp_data 0; busy 0; op_count 0; latched operands 0; grant index 0.
- States: IDLE, CALC, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; handshake completes that cycle.
  - At the clock edge, latch req_a/req_b slice g and g, then go to CALC.
  - No req_valid set: stay in IDLE, all req_ready 0.
- CALC (exactly 1 cycle):
  - rsp_data <= a_lat * b_lat as a full 2*WIDTH unsigned product (no truncation, no overflow).
  - Go to RESP.
- RESP:
  - rsp_valid[g]=1; rsp_data stable until the handshake.
  - On rsp_ready[g]=1: op_count +1; rr_ptr <= (g+1) mod NREQ; go to IDLE.
  - rsp_ready on non-granted indices is ignored.
  - The response may be held indefinitely; all req_ready stay 0 meanwhile.
- Latency and throughput:
  - Accept to rsp_valid: 2 cycles.
  - Minimum issue interval: 3 cycles, with rsp_ready held high.
- req_ready is 0 in CALC and RESP; requests wait. A requester may change operands while not granted.
- req_valid withdrawn without a handshake has no effect; no operation starts for it.
- Fairness:
  - A requester that completed an operation has lowest priority for the next grant.
  - With all NREQ requesting continuously, grants cycle 0,1,...,NREQ-1,0.
- Edge operands:
  - 0 x anything = 0.
  - (2^WIDTH-1)^2 = 0xFFFFFFFE00000001 for WIDTH=32.
- op_count wraps from 2^CNTW-1 to 0.
- Reset mid-operation (CALC or RESP): in-flight result is discarded, no rsp_valid pulse, and all registers return to their reset values immediately.
- rr_ptr changes only on a response handshake, never on a request grant.

Test Plan:
- Reset, then req_valid=4'b0001 with a=3, b=5 → req_ready[0]=1 in the same cycle; rsp_valid[0]=1 two cycles later; rsp_data=15; op_count=1.
- a=b=0xFFFFFFFF on requester 2 → rsp_data=0xFFFFFFFE00000001; a=0, b=0xDEADBEEF → rsp_data=0.
- req_valid=4'b1111 held high, rsp_ready=4'b1111 → grants in order 0,1,2,3,0; one result every 3 cycles; op_count=5 after five results.
- Requester 1 in RESP with rsp_ready[1]=0 for 10 cycles while requester 3 requests → rsp_valid[1] and rsp_data held stable, req_ready stays 0; after rsp_ready[1] pulses, requester 3 is granted next cycle.
- Reset during CALC, then during RESP → no rsp_valid asserted, op_count=0, rr_ptr=0; next request from requester 0 is granted first.
- Preload op_count to 0xFFFF via 65535 operations (or force) → next completion sets op_count=0x0000.
